// File: rtl/sensor_reset_sequencer_if.sv
// rtl/sensor_reset_sequencer_if.sv - sensor controller status inputs and reset/status outputs of the sequencer
interface sensor_reset_sequencer_if;
  logic       ctrl_initialized;
  logic       ctrl_error;
  logic       data_valid;
  logic       soft_reset_req;
  logic       bno085_rst_n;
  logic       ctrl_rst_n;
  logic       running;
  logic       failed;
  logic [3:0] retry_count;

  modport master (
    output ctrl_initialized, ctrl_error, data_valid, soft_reset_req,
    input  bno085_rst_n, ctrl_rst_n, running, failed, retry_count
  );

  modport slave (
    input  ctrl_initialized, ctrl_error, data_valid, soft_reset_req,
    output bno085_rst_n, ctrl_rst_n, running, failed, retry_count
  );
endinterface

// File: rtl/sensor_reset_sequencer.sv
// rtl/sensor_reset_sequencer.sv - BNO085 power-up/reset sequencer with retry and optional stall watchdog
// Optional feature: define SENSOR_STALL_WATCHDOG_EN to fault RUN when data_valid goes quiet.
module sensor_reset_sequencer #(
  parameter int RST_HOLD_CYC      = 300000,
  parameter int BOOT_WAIT_CYC     = 5700000,
  parameter int INIT_TIMEOUT_CYC  = 3000000,
  parameter int STALL_TIMEOUT_CYC = 300000,
  parameter int MAX_RETRIES       = 3
) (
  input  logic                    clk,
  input  logic                    fpga_rst_n,
  sensor_reset_sequencer_if.slave seq
);

  localparam logic [2:0] HOLD_RST  = 3'd0;
  localparam logic [2:0] BOOT_WAIT = 3'd1;
  localparam logic [2:0] INIT_WAIT = 3'd2;
  localparam logic [2:0] RUN       = 3'd3;
  localparam logic [2:0] FAILED    = 3'd4;

  localparam logic [22:0] HOLD_LAST = 23'(RST_HOLD_CYC - 1);
  localparam logic [22:0] BOOT_LAST = 23'(BOOT_WAIT_CYC - 1);
  localparam logic [22:0] INIT_LAST = 23'(INIT_TIMEOUT_CYC - 1);
  localparam logic [3:0]  MAX_R     = 4'(MAX_RETRIES);

  logic [1:0]  rst_sync;
  logic        sys_rst_n;
  logic [2:0]  state, state_nxt;
  logic [22:0] cnt, cnt_nxt;
  logic [3:0]  retry_q, retry_nxt;
  logic        fault;
  logic        bno_rst_q, ctrl_rst_q, running_q, failed_q;

  // Assertion passes straight through; release is delayed by two clk edges.
  always_ff @(posedge clk or negedge fpga_rst_n) begin
    if (!fpga_rst_n) rst_sync <= 2'b00;
    else             rst_sync <= {rst_sync[0], 1'b1};
  end
  assign sys_rst_n = rst_sync[1];

`ifdef SENSOR_STALL_WATCHDOG_EN
  localparam logic [22:0] STALL_LAST = 23'(STALL_TIMEOUT_CYC - 1);
`else
  logic data_valid_unused;
  assign data_valid_unused = seq.data_valid;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 23'd1;
    retry_nxt = retry_q;
    fault     = 1'b0;
    case (state)
      HOLD_RST: if (cnt == HOLD_LAST) begin
        state_nxt = BOOT_WAIT;
        cnt_nxt   = 23'd0;
      end
      BOOT_WAIT: if (cnt == BOOT_LAST) begin
        state_nxt = INIT_WAIT;
        cnt_nxt   = 23'd0;
      end
      INIT_WAIT: begin
        // Error beats init-done; init-done on the last allowed cycle still counts.
        if (seq.ctrl_error) begin
          fault = 1'b1;
        end else if (seq.ctrl_initialized) begin
          state_nxt = RUN;
          cnt_nxt   = 23'd0;
        end else if (cnt == INIT_LAST) begin
          fault = 1'b1;
        end
      end
      RUN: begin
`ifdef SENSOR_STALL_WATCHDOG_EN
        if (seq.data_valid) cnt_nxt = 23'd0;
        if (seq.ctrl_error) fault = 1'b1;
        else if (!seq.data_valid && cnt == STALL_LAST) fault = 1'b1;
`else
        cnt_nxt = 23'd0;
        if (seq.ctrl_error) fault = 1'b1;
`endif
      end
      FAILED:  cnt_nxt = 23'd0;
      default: begin
        state_nxt = HOLD_RST;
        cnt_nxt   = 23'd0;
      end
    endcase

    if (fault) begin
      cnt_nxt = 23'd0;
      if (retry_q < MAX_R) begin
        retry_nxt = retry_q + 4'd1;
        state_nxt = HOLD_RST;
      end else begin
        state_nxt = FAILED;
      end
    end

    if (seq.soft_reset_req) begin
      state_nxt = HOLD_RST;
      cnt_nxt   = 23'd0;
      retry_nxt = 4'd0;
    end
  end

  // Outputs are decoded from state_nxt so they flip on the same edge as the state.
  always_ff @(posedge clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= HOLD_RST;
      cnt        <= 23'd0;
      retry_q    <= 4'd0;
      bno_rst_q  <= 1'b0;
      ctrl_rst_q <= 1'b0;
      running_q  <= 1'b0;
      failed_q   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      retry_q    <= retry_nxt;
      bno_rst_q  <= (state_nxt == BOOT_WAIT) || (state_nxt == INIT_WAIT) || (state_nxt == RUN);
      ctrl_rst_q <= (state_nxt == INIT_WAIT) || (state_nxt == RUN);
      running_q  <= (state_nxt == RUN);
      failed_q   <= (state_nxt == FAILED);
    end
  end

  assign seq.bno085_rst_n = bno_rst_q;
  assign seq.ctrl_rst_n   = ctrl_rst_q;
  assign seq.running      = running_q;
  assign seq.failed       = failed_q;
  assign seq.retry_count  = retry_q;

endmodule

// File: tb/tb_sensor_reset_sequencer.sv
// tb/tb_sensor_reset_sequencer.sv - directed-vector bench for sensor_reset_sequencer (SENSOR_STALL_WATCHDOG_EN selects stall expectations)
module tb_sensor_reset_sequencer;
  logic clk = 1'b0;
  logic clk_en = 1'b1;
  logic fpga_rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  sensor_reset_sequencer_if seq_if ();

  sensor_reset_sequencer #(
    .RST_HOLD_CYC      (4),
    .BOOT_WAIT_CYC     (8),
    .INIT_TIMEOUT_CYC  (16),
    .STALL_TIMEOUT_CYC (10),
    .MAX_RETRIES       (2)
  ) dut (
    .clk        (clk),
    .fpga_rst_n (fpga_rst_n),
    .seq        (seq_if)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_soft_reset();
    seq_if.soft_reset_req = 1'b1;
    tick(1);
    seq_if.soft_reset_req = 1'b0;
  endtask

  // Entered just after the edge that put the DUT in HOLD_RST with a cleared counter.
  task automatic bring_up(input string tag);
    tick(3);
    check_eq({tag, "_hold_bno"}, 4'(seq_if.bno085_rst_n), 4'd0);
    tick(1);
    check_eq({tag, "_boot_bno"}, 4'(seq_if.bno085_rst_n), 4'd1);
    check_eq({tag, "_boot_ctrl"}, 4'(seq_if.ctrl_rst_n), 4'd0);
    tick(8);
    check_eq({tag, "_init_ctrl"}, 4'(seq_if.ctrl_rst_n), 4'd1);
    check_eq({tag, "_init_run"}, 4'(seq_if.running), 4'd0);
    seq_if.ctrl_initialized = 1'b1;
    tick(1);
    seq_if.ctrl_initialized = 1'b0;
    check_eq({tag, "_run"}, 4'(seq_if.running), 4'd1);
  endtask

  initial begin
    seq_if.ctrl_initialized = 1'b0;
    seq_if.ctrl_error       = 1'b0;
    seq_if.data_valid       = 1'b0;
    seq_if.soft_reset_req   = 1'b0;

    tick(3);
    check_eq("rst_bno", 4'(seq_if.bno085_rst_n), 4'd0);
    check_eq("rst_ctrl", 4'(seq_if.ctrl_rst_n), 4'd0);
    check_eq("rst_running", 4'(seq_if.running), 4'd0);
    check_eq("rst_failed", 4'(seq_if.failed), 4'd0);
    check_eq("rst_retry", seq_if.retry_count, 4'd0);

    // Nominal: two sync edges, then 4 hold, 8 boot, init done on INIT_WAIT cycle 3.
    fpga_rst_n = 1'b1;
    tick(5);
    check_eq("nom_bno_before", 4'(seq_if.bno085_rst_n), 4'd0);
    tick(1);
    check_eq("nom_bno_rise", 4'(seq_if.bno085_rst_n), 4'd1);
    tick(7);
    check_eq("nom_ctrl_before", 4'(seq_if.ctrl_rst_n), 4'd0);
    tick(1);
    check_eq("nom_ctrl_rise", 4'(seq_if.ctrl_rst_n), 4'd1);
    tick(3);
    seq_if.ctrl_initialized = 1'b1;
    check_eq("nom_run_before", 4'(seq_if.running), 4'd0);
    tick(1);
    seq_if.ctrl_initialized = 1'b0;
    check_eq("nom_running", 4'(seq_if.running), 4'd1);

    // Stall: data_valid every 5 cycles, then silence.
    for (int i = 0; i < 6; i++) begin
      seq_if.data_valid = 1'b1;
      tick(1);
      seq_if.data_valid = 1'b0;
      tick(4);
    end
    check_eq("stall_fed_running", 4'(seq_if.running), 4'd1);
    tick(5);
    check_eq("stall_idle9_running", 4'(seq_if.running), 4'd1);
    tick(1);
`ifdef SENSOR_STALL_WATCHDOG_EN
    check_eq("stall_trip_running", 4'(seq_if.running), 4'd0);
    check_eq("stall_trip_bno", 4'(seq_if.bno085_rst_n), 4'd0);
    check_eq("stall_trip_retry", seq_if.retry_count, 4'd1);
`else
    check_eq("nostall_running", 4'(seq_if.running), 4'd1);
    check_eq("nostall_retry", seq_if.retry_count, 4'd0);
`endif

    // Priority: soft reset beats ctrl_error; ctrl_error alone counts a retry.
    pulse_soft_reset();
    bring_up("prio_a");
    seq_if.ctrl_error     = 1'b1;
    seq_if.soft_reset_req = 1'b1;
    tick(1);
    seq_if.ctrl_error     = 1'b0;
    seq_if.soft_reset_req = 1'b0;
    check_eq("prio_both_running", 4'(seq_if.running), 4'd0);
    check_eq("prio_both_retry", seq_if.retry_count, 4'd0);
    check_eq("prio_both_bno", 4'(seq_if.bno085_rst_n), 4'd0);
    bring_up("prio_b");
    seq_if.ctrl_error = 1'b1;
    tick(1);
    seq_if.ctrl_error = 1'b0;
    check_eq("prio_err_running", 4'(seq_if.running), 4'd0);
    check_eq("prio_err_retry", seq_if.retry_count, 4'd1);

    // Init timeout: 28 cycles per attempt, third failure lands in FAILED.
    pulse_soft_reset();
    check_eq("to_retry_clear", seq_if.retry_count, 4'd0);
    tick(27);
    check_eq("to_a1_retry", seq_if.retry_count, 4'd0);
    check_eq("to_a1_ctrl", 4'(seq_if.ctrl_rst_n), 4'd1);
    tick(1);
    check_eq("to_a1_end_retry", seq_if.retry_count, 4'd1);
    check_eq("to_a1_end_ctrl", 4'(seq_if.ctrl_rst_n), 4'd0);
    tick(55);
    check_eq("to_a3_failed", 4'(seq_if.failed), 4'd0);
    check_eq("to_a3_retry", seq_if.retry_count, 4'd2);
    tick(1);
    check_eq("to_failed", 4'(seq_if.failed), 4'd1);
    check_eq("to_failed_retry", seq_if.retry_count, 4'd2);
    check_eq("to_failed_bno", 4'(seq_if.bno085_rst_n), 4'd0);
    tick(50);
    check_eq("to_hold_failed", 4'(seq_if.failed), 4'd1);
    check_eq("to_hold_bno", 4'(seq_if.bno085_rst_n), 4'd0);

    // Recovery from FAILED.
    pulse_soft_reset();
    check_eq("rec_failed", 4'(seq_if.failed), 4'd0);
    check_eq("rec_retry", seq_if.retry_count, 4'd0);
    bring_up("rec");

    // Async reset mid-BOOT_WAIT with the clock stopped.
    pulse_soft_reset();
    tick(7);
    check_eq("async_pre_bno", 4'(seq_if.bno085_rst_n), 4'd1);
    clk_en = 1'b0;
    #20;
    fpga_rst_n = 1'b0;
    #2;
    check_eq("async_bno", 4'(seq_if.bno085_rst_n), 4'd0);
    check_eq("async_ctrl", 4'(seq_if.ctrl_rst_n), 4'd0);
    clk_en = 1'b1;
    tick(3);
    fpga_rst_n = 1'b1;
    tick(5);
    check_eq("async_restart_hold", 4'(seq_if.bno085_rst_n), 4'd0);
    tick(1);
    check_eq("async_restart_boot", 4'(seq_if.bno085_rst_n), 4'd1);
    check_eq("async_restart_retry", seq_if.retry_count, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
